// File: rtl/retry_pkg.sv
// Shared types and constants for the link-layer retry block.
//   lrsm_state_e   : Local Retry State Machine state encoding (4 bits)
//   PHY_STS_REINIT : PHY state status value that signals reinit has been reached
package retry_pkg;

  typedef enum logic [3:0] {
    StLocalNormal = 4'd0,
    StLlrreq      = 4'd1,
    StLocalIdle   = 4'd2,
    StPhyReinit   = 4'd3,
    StAbort       = 4'd4
  } lrsm_state_e;

  localparam logic [3:0] PHY_STS_REINIT = 4'h0;

endpackage

// File: rtl/retry_lrsm_ctrl_if.sv
// Signal bundle between the LRSM controller and its surroundings.
// Names are from the controller's point of view (i_ = into it, o_ = out of it).
//   slave  : controller side
//   master : environment side (unpacker, link controller, PHY, register file)
interface retry_lrsm_ctrl_if #(
  parameter int unsigned CNT_W = 5,
  parameter int unsigned TMO_W = 13
);
  logic             i_flit_valid;
  logic             i_crc_err;
  logic             i_req_sent;
  logic             i_ack_rcvd;
  logic             i_flit_tick;
  logic             i_pl_lnk_up;
  logic [3:0]       i_pl_state_sts;
  logic [CNT_W-1:0] i_retry_threshold;
  logic [CNT_W-1:0] i_reinit_threshold;
  logic [TMO_W-1:0] i_timeout_max;
  logic [3:0]       o_lrsm_state;
  logic             o_send_req_seq;
  logic             o_phy_reinit_req;
  logic             o_discard_rx;
  logic             o_link_failure;
  logic [CNT_W-1:0] o_num_retry;
  logic [CNT_W-1:0] o_num_phy_reinit;
  logic             o_retry_threshold_hit;
  logic             o_reinit_threshold_hit;

  modport slave (
    input  i_flit_valid, i_crc_err, i_req_sent, i_ack_rcvd, i_flit_tick, i_pl_lnk_up,
           i_pl_state_sts, i_retry_threshold, i_reinit_threshold, i_timeout_max,
    output o_lrsm_state, o_send_req_seq, o_phy_reinit_req, o_discard_rx, o_link_failure,
           o_num_retry, o_num_phy_reinit, o_retry_threshold_hit, o_reinit_threshold_hit
  );

  modport master (
    output i_flit_valid, i_crc_err, i_req_sent, i_ack_rcvd, i_flit_tick, i_pl_lnk_up,
           i_pl_state_sts, i_retry_threshold, i_reinit_threshold, i_timeout_max,
    input  o_lrsm_state, o_send_req_seq, o_phy_reinit_req, o_discard_rx, o_link_failure,
           o_num_retry, o_num_phy_reinit, o_retry_threshold_hit, o_reinit_threshold_hit
  );
endinterface

// File: rtl/retry_timeout_cnt.sv
// Retry-timeout counter: saturating TMO_W-bit flit-tick counter.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : synchronous clear (has priority over i_tick)
//   i_tick       : increment enable
//   i_max        : timeout threshold
//   o_expired    : count >= i_max
module retry_timeout_cnt #(
  parameter int unsigned TMO_W = 13
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_tick,
  input  logic [TMO_W-1:0] i_max,
  output logic             o_expired
);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_tick && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt >= i_max);

endmodule

// File: rtl/retry_lrsm_ctrl.sv
// Local Retry State Machine controller. Watches receive CRC status, sequences
// RETRY.Req transmission and the retry-timeout window, escalates to PHY reinit
// and finally to a terminal link abort.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   io_bus       : retry_lrsm_ctrl_if.slave (CRC status, req/ack pulses, flit tick,
//                  PHY status, thresholds in; state, counters, pulses out)
module retry_lrsm_ctrl
  import retry_pkg::*;
#(
  parameter int unsigned CNT_W = 5,
  parameter int unsigned TMO_W = 13
) (
  input logic                i_clk,
  input logic                i_rst,
  retry_lrsm_ctrl_if.slave   io_bus
);

  lrsm_state_e      r_state, w_state_d;
  logic [CNT_W-1:0] r_num_retry, w_num_retry_d;
  logic [CNT_W-1:0] r_num_phy_reinit, w_num_phy_reinit_d;
  logic             r_reinit_seen, w_reinit_seen_d;
  logic             r_phy_reinit_req, w_phy_reinit_req_d;
  logic             r_retry_hit, w_retry_hit_d;
  logic             r_reinit_hit, w_reinit_hit_d;
  logic             w_retry_thr, w_abort_thr;
  logic             w_tmo_clear, w_tmo_tick, w_tmo_expired;

  assign w_retry_thr = (r_num_retry >= io_bus.i_retry_threshold);
  assign w_abort_thr = w_retry_thr && (r_num_phy_reinit >= io_bus.i_reinit_threshold);

  // Only counts while waiting for an Ack; cleared whenever a new Req goes out.
  assign w_tmo_clear = (r_state == StLlrreq) && !w_retry_thr && io_bus.i_req_sent;
  assign w_tmo_tick  = (r_state == StLocalIdle) && io_bus.i_flit_tick;

  retry_timeout_cnt #(
    .TMO_W (TMO_W)
  ) u_tmo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_tmo_clear),
    .i_tick    (w_tmo_tick),
    .i_max     (io_bus.i_timeout_max),
    .o_expired (w_tmo_expired)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StLocalNormal;
    else       r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StLocalNormal: if (io_bus.i_flit_valid && io_bus.i_crc_err) w_state_d = StLlrreq;
      StLlrreq: begin
        if (w_abort_thr)            w_state_d = StAbort;
        else if (w_retry_thr)       w_state_d = StPhyReinit;
        else if (io_bus.i_req_sent) w_state_d = StLocalIdle;
      end
      StLocalIdle: begin
        if (io_bus.i_ack_rcvd)  w_state_d = StLocalNormal;
        else if (w_tmo_expired) w_state_d = StLlrreq;
      end
      StPhyReinit: if (r_reinit_seen && io_bus.i_pl_lnk_up) w_state_d = StLlrreq;
      StAbort:     w_state_d = StAbort;
      default:     w_state_d = StLocalNormal;
    endcase
  end

  // Counter, flag and pulse next values; pulses land in the first cycle of the new state.
  always_comb begin
    w_num_retry_d      = r_num_retry;
    w_num_phy_reinit_d = r_num_phy_reinit;
    w_reinit_seen_d    = r_reinit_seen;
    w_phy_reinit_req_d = 1'b0;
    w_retry_hit_d      = 1'b0;
    w_reinit_hit_d     = 1'b0;
    case (r_state)
      StLlrreq: begin
        if (w_abort_thr) begin
          w_reinit_hit_d = 1'b1;
        end else if (w_retry_thr) begin
          w_retry_hit_d      = 1'b1;
          w_phy_reinit_req_d = 1'b1;
          w_num_retry_d      = '0;
          w_reinit_seen_d    = 1'b0;
          if (r_num_phy_reinit != '1) w_num_phy_reinit_d = r_num_phy_reinit + 1'b1;
        end else if (io_bus.i_req_sent) begin
          if (r_num_retry != '1) w_num_retry_d = r_num_retry + 1'b1;
        end
      end
      StLocalIdle: begin
        if (io_bus.i_ack_rcvd) begin
          w_num_retry_d      = '0;
          w_num_phy_reinit_d = '0;
        end
      end
      StPhyReinit: if (io_bus.i_pl_state_sts == PHY_STS_REINIT) w_reinit_seen_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_num_retry      <= '0;
      r_num_phy_reinit <= '0;
      r_reinit_seen    <= 1'b0;
      r_phy_reinit_req <= 1'b0;
      r_retry_hit      <= 1'b0;
      r_reinit_hit     <= 1'b0;
    end else begin
      r_num_retry      <= w_num_retry_d;
      r_num_phy_reinit <= w_num_phy_reinit_d;
      r_reinit_seen    <= w_reinit_seen_d;
      r_phy_reinit_req <= w_phy_reinit_req_d;
      r_retry_hit      <= w_retry_hit_d;
      r_reinit_hit     <= w_reinit_hit_d;
    end
  end

  // Output decode
  always_comb begin
    io_bus.o_lrsm_state           = r_state;
    io_bus.o_send_req_seq         = (r_state == StLlrreq) && !w_retry_thr;
    io_bus.o_discard_rx           = (r_state != StLocalNormal);
    io_bus.o_link_failure         = (r_state == StAbort);
    io_bus.o_num_retry            = r_num_retry;
    io_bus.o_num_phy_reinit       = r_num_phy_reinit;
    io_bus.o_phy_reinit_req       = r_phy_reinit_req;
    io_bus.o_retry_threshold_hit  = r_retry_hit;
    io_bus.o_reinit_threshold_hit = r_reinit_hit;
  end

endmodule

// File: doc/retry_lrsm_ctrl.md
# retry_lrsm_ctrl

Local Retry State Machine (LRSM) controller for the CXL link-layer retry block. It watches receive CRC status, sequences LLRREQ/RETRY.Req transmission and the retry-timeout window, and escalates to PHY re-initialisation and finally link abort. It sits between the unpacker/CRC checker and the link-layer controller, and drives the LRSM state, retry counters and threshold-hit indications consumed by the control-flit packer and the register file.

## Interface
Parameters:
- CNT_W, 5, width of NUM_RETRY / NUM_PHY_REINIT counters and thresholds
- TMO_W, 13, width of the retry-timeout counter and threshold

Ports (one clock `i_clk`; reset `i_rst` is asynchronous and active-high):
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_flit_valid  in  1  received flit valid this cycle
- i_crc_err  in  1  received flit failed CRC; qualified by i_flit_valid
- i_req_sent  in  1  controller has transmitted RETRY.Req (1-cycle pulse)
- i_ack_rcvd  in  1  valid RETRY.Ack received (1-cycle pulse)
- i_flit_tick  in  1  one flit transfer slot elapsed (timeout increment)
- i_pl_lnk_up  in  1  PHY link up
- i_pl_state_sts  in  4  PHY state; 4'h0 = PHY reinit reached
- i_retry_threshold  in  CNT_W  max RETRY.Req attempts before PHY reinit
- i_reinit_threshold  in  CNT_W  max PHY reinits before abort
- i_timeout_max  in  TMO_W  retry timeout in flit ticks
- o_lrsm_state  out  4  current LRSM state encoding
- o_send_req_seq  out  1  request controller to send RETRY.Req
- o_phy_reinit_req  out  1  1-cycle PHY reinit request
- o_discard_rx  out  1  discard received flits
- o_link_failure  out  1  sticky link-failure indication
- o_num_retry  out  CNT_W  NUM_RETRY counter
- o_num_phy_reinit  out  CNT_W  NUM_PHY_REINIT counter
- o_retry_threshold_hit  out  1  1-cycle pulse
- o_reinit_threshold_hit  out  1  1-cycle pulse

## Operation
- States: LOCAL_NORMAL=0, LLRREQ=1, LOCAL_IDLE=2, PHY_REINIT=3, ABORT=4.
- LOCAL_NORMAL: i_flit_valid & i_crc_err -> LLRREQ.
- LLRREQ is evaluated in priority order:
  - num_retry >= i_retry_threshold and num_phy_reinit >= i_reinit_threshold -> ABORT; pulse o_reinit_threshold_hit.
  - Else num_retry >= i_retry_threshold -> PHY_REINIT; pulse o_retry_threshold_hit.
  - Else i_req_sent -> LOCAL_IDLE; num_retry++ and clear the timeout counter.
- LOCAL_IDLE:
  - i_ack_rcvd -> LOCAL_NORMAL; clear num_retry and num_phy_reinit.
  - Else timeout counter reaches i_timeout_max -> LLRREQ.
  - The counter increments on i_flit_tick, saturating at all-ones.
- PHY_REINIT:
  - On entry: o_phy_reinit_req pulses, num_phy_reinit++, num_retry cleared, reinit_seen flag cleared.
  - i_pl_state_sts==4'h0 sets reinit_seen.
  - reinit_seen & i_pl_lnk_up -> LLRREQ.
- ABORT: terminal. o_link_failure=1; only i_rst exits.
- o_send_req_seq = (state==LLRREQ) & no threshold hit this cycle.
- o_discard_rx = state in {LLRREQ, LOCAL_IDLE, PHY_REINIT, ABORT}.
- Counters saturate at 2^CNT_W-1. Threshold 0 means escalate on the first LLRREQ evaluation. i_timeout_max=0 times out on the first cycle in LOCAL_IDLE.

## Timing
- All outputs are registered or decoded from registered state. Reset values: o_lrsm_state=0, all other outputs 0, counters 0, timeout counter 0.
- Input sampled in cycle N -> new state and counters visible in cycle N+1.
- The o_phy_reinit_req and threshold-hit pulses assert in the first cycle of the new state, for exactly one cycle.
- Simultaneous events in LOCAL_IDLE: i_ack_rcvd beats a timeout.
- CRC errors outside LOCAL_NORMAL are ignored. i_ack_rcvd outside LOCAL_IDLE is ignored.
- In LLRREQ, a threshold check beats a same-cycle i_req_sent, and that request is not counted.
- Reset asserted mid-sequence returns everything to reset values asynchronously; no pending pulse survives.

## Structure
- Shared package `retry_pkg`:
  - `lrsm_state_e` (4-bit enum, encodings above)
  - PHY_STS_REINIT = 4'h0
- Sub-module `retry_timeout_cnt`: clear, tick enable, saturating TMO_W counter, `o_expired` (count >= max).
- The FSM and counters live in the top module.

## Test plan
- Single CRC error, i_req_sent 3 cycles later, i_ack_rcvd 5 ticks later with i_timeout_max=20 -> states 0->1->2->0; o_num_retry 0->1->0; no reinit.
- i_retry_threshold=2, i_timeout_max=4, never ack -> two timeouts, then o_retry_threshold_hit pulse, PHY_REINIT, o_phy_reinit_req one cycle, o_num_phy_reinit=1, o_num_retry=0.
- In PHY_REINIT, i_pl_lnk_up=1 before i_pl_state_sts=0 -> stays. Then sts=0 followed by lnk_up=1 -> LLRREQ.
- i_reinit_threshold=1, i_retry_threshold=1, no acks -> after one reinit cycle reaches ABORT, o_reinit_threshold_hit pulse; o_link_failure stays 1 until i_rst.
- i_ack_rcvd and timeout expiry in the same cycle -> LOCAL_NORMAL, counters cleared.
- Assert i_rst while in LOCAL_IDLE with num_retry=3 -> all outputs 0 immediately; CRC error after release restarts from num_retry=0.
